// File: rtl/cpu_pkg.sv
// Shared constants for the multi-cycle CPU control sequencer: widths, opcodes and
// the sequencer state encoding.
package cpu_pkg;

   localparam int unsigned PC_W   = 10;
   localparam int unsigned DATA_W = 19;

   localparam logic [4:0] OP_BEQ  = 5'h10;
   localparam logic [4:0] OP_BNE  = 5'h11;
   localparam logic [4:0] OP_JMP  = 5'h12;
   localparam logic [4:0] OP_HALT = 5'h1F;

   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5
   } state_e;

   // Branch and jump opcodes complete in EXEC; HALT is handled separately.
   function automatic logic is_flow_op(input logic [4:0] op);
      return (op == OP_BEQ) || (op == OP_BNE) || (op == OP_JMP);
   endfunction

endpackage

// File: rtl/cpu_branch_unit.sv
// Combinational branch resolution: decides whether a BEQ/BNE/JMP is taken and
// produces the next PC for control-flow instructions.
module cpu_branch_unit #(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned DATA_W = 19
) (
   input  logic [PC_W-1:0]   i_pc,
   input  logic [DATA_W-1:0] i_ir,
   input  logic              i_zero,
   output logic              o_is_flow,
   output logic              o_taken,
   output logic [PC_W-1:0]   o_pc_inc,
   output logic [PC_W-1:0]   o_flow_pc
);
   import cpu_pkg::*;

   logic [4:0]      w_op;
   logic [PC_W-1:0] w_imm;
   logic [PC_W-1:0] w_rel_target;
   logic [PC_W-1:0] w_target;

   assign w_op     = i_ir[DATA_W-1 -: 5];
   assign w_imm    = {{(PC_W-6){i_ir[5]}}, i_ir[5:0]};
   // All PC arithmetic is modulo 2^PC_W, so 1023 + 1 wraps to 0.
   assign o_pc_inc     = i_pc + PC_W'(1);
   assign w_rel_target = o_pc_inc + w_imm;
   assign o_is_flow    = is_flow_op(w_op);

   always_comb begin
      o_taken  = 1'b0;
      w_target = w_rel_target;
      if (w_op == OP_BEQ) begin
         o_taken = i_zero;
      end else if (w_op == OP_BNE) begin
         o_taken = ~i_zero;
      end else if (w_op == OP_JMP) begin
         o_taken  = 1'b1;
         w_target = i_ir[PC_W-1:0];
      end
   end

   assign o_flow_pc = o_taken ? w_target : o_pc_inc;

endmodule

// File: rtl/cpu_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB control sequencer: owns PC, IR and the
// retired counter, and gates register-file and RAM strobes once per instruction.
module cpu_sequencer #(
   parameter int unsigned PC_W   = 10,
   parameter int unsigned DATA_W = 19,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [DATA_W-1:0] rom_dout,
   input  logic              zero,
   input  logic              cu_reg_write,
   input  logic              cu_mem_read,
   input  logic              cu_mem_write,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] ir,
   output logic              rf_we,
   output logic              ram_en,
   output logic              ram_we,
   output logic              halted,
   output logic [2:0]        state_out,
   output logic [CNT_W-1:0]  retired
);
   import cpu_pkg::*;

   state_e            r_state;
   state_e            w_state_nxt;
   logic [PC_W-1:0]   r_pc;
   logic [PC_W-1:0]   w_pc_nxt;
   logic [DATA_W-1:0] r_ir;
   logic [DATA_W-1:0] w_ir_nxt;
   logic [CNT_W-1:0]  r_retired;
   logic              w_retire;

   logic [4:0]        w_op;
   logic              w_is_flow;
   logic              w_taken;
   logic [PC_W-1:0]   w_pc_inc;
   logic [PC_W-1:0]   w_flow_pc;

   logic              w_rf_we;
   logic              w_ram_en;
   logic              w_ram_we;
   logic              w_halted;

   assign w_op = r_ir[DATA_W-1 -: 5];

   cpu_branch_unit #(
      .PC_W   (PC_W),
      .DATA_W (DATA_W)
   ) u_branch (
      .i_pc      (r_pc),
      .i_ir      (r_ir),
      .i_zero    (zero),
      .o_is_flow (w_is_flow),
      .o_taken   (w_taken),
      .o_pc_inc  (w_pc_inc),
      .o_flow_pc (w_flow_pc)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= StFetch;
         r_pc      <= '0;
         r_ir      <= '0;
         r_retired <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_ir    <= w_ir_nxt;
         if (w_retire) begin
            r_retired <= r_retired + CNT_W'(1);
         end
      end
   end

   // Strobes depend only on the state register and the IR-derived cu_* flags,
   // so zero never reaches an output combinationally.
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_ir_nxt    = r_ir;
      w_rf_we     = 1'b0;
      w_ram_en    = 1'b0;
      w_ram_we    = 1'b0;
      w_halted    = 1'b0;
      unique case (r_state)
         StFetch: begin
            if (run) begin
               w_state_nxt = StDecode;
            end
         end
         StDecode: begin
            w_ir_nxt    = rom_dout;
            w_state_nxt = StExec;
         end
         StExec: begin
            if (w_op == OP_HALT) begin
               w_state_nxt = StHalt;
            end else if (w_is_flow) begin
               w_pc_nxt    = w_flow_pc;
               w_state_nxt = StFetch;
            end else if (cu_mem_read || cu_mem_write) begin
               w_state_nxt = StMem;
            end else if (cu_reg_write) begin
               w_state_nxt = StWb;
            end else begin
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = StFetch;
            end
         end
         StMem: begin
            w_ram_en = 1'b1;
            w_ram_we = cu_mem_write;
            // A store wins over a simultaneous load and skips write-back.
            if (cu_mem_write) begin
               w_pc_nxt    = w_pc_inc;
               w_state_nxt = StFetch;
            end else begin
               w_state_nxt = StWb;
            end
         end
         StWb: begin
            w_rf_we     = cu_reg_write;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = StFetch;
         end
         StHalt: begin
            w_halted = 1'b1;
         end
         default: begin
            w_state_nxt = StFetch;
         end
      endcase
   end

   assign w_retire = ((r_state != StFetch) && (w_state_nxt == StFetch)) ||
                     ((r_state != StHalt)  && (w_state_nxt == StHalt));

   assign pc        = r_pc;
   assign ir        = r_ir;
   assign rf_we     = w_rf_we;
   assign ram_en    = w_ram_en;
   assign ram_we    = w_ram_we;
   assign halted    = w_halted;
   assign state_out = r_state;
   assign retired   = r_retired;

endmodule
